// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_ctrl_pkg;

  localparam int DATA_W   = 16;
  localparam int REG_ZERO = 0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MUL_WAIT = 2'd1,
    FLUSH    = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags an ID instruction that reads the register a load in EX
// has not yet produced. Register 0 never creates a dependency.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 4
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  output logic              lu_hazard
);

  logic rs1_match;
  logic rs2_match;

  assign rs1_match = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_match = id_use_rs2 && (id_rs2 == ex_rd);

  assign lu_hazard = id_valid && ex_valid && ex_memread &&
                     (ex_rd != REG_AW'(REG_ZERO)) && (rs1_match || rs2_match);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing controller: load-use bubbles, branch squash, multiply hold.
// Optional statistics counters are built only when HAZARD_STATS_EN is defined.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW      = 4,
  parameter int MUL_CYCLES  = 4,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              id_is_mul,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic              ex_branch_taken,
  output logic              pc_en,
  output logic              ifid_en,
  output logic              ifid_flush,
  output logic              idex_en,
  output logic              idex_flush,
  output logic              mul_busy,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // The counter is shared by the multiply hold and the branch squash, so it must fit both reloads.
  localparam int MUL_BITS   = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam int FLUSH_BITS = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;
  localparam int CNT_BITS   = (MUL_BITS > FLUSH_BITS) ? MUL_BITS : FLUSH_BITS;
  localparam int MUL_RELOAD   = MUL_CYCLES - 2;
  localparam int FLUSH_RELOAD = (FLUSH_DEPTH > 1) ? FLUSH_DEPTH - 2 : 0;

  ctrl_state_e         state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                lu_hazard;

  hazard_detect #(
    .REG_AW(REG_AW)
  ) u_hazard_detect (
    .id_valid  (id_valid),
    .id_rs1    (id_rs1),
    .id_rs2    (id_rs2),
    .id_use_rs1(id_use_rs1),
    .id_use_rs2(id_use_rs2),
    .ex_valid  (ex_valid),
    .ex_rd     (ex_rd),
    .ex_memread(ex_memread),
    .lu_hazard (lu_hazard)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    idex_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    mul_busy   = 1'b0;

    case (state_q)
      RUN: begin
        if (ex_branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (FLUSH_DEPTH > 1) begin
            state_d = FLUSH;
            cnt_d   = CNT_BITS'(FLUSH_RELOAD);
          end
        end else if (lu_hazard) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
        end else if (id_valid && id_is_mul) begin
          state_d = MUL_WAIT;
          cnt_d   = CNT_BITS'(MUL_RELOAD);
        end
      end
      MUL_WAIT: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        mul_busy = 1'b1;
        if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FLUSH: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (ex_branch_taken) begin
          cnt_d = CNT_BITS'(FLUSH_RELOAD);
        end else if (cnt_q == '0) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        // Unreachable encoding: inject a bubble and recover to RUN.
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        state_d    = RUN;
        cnt_d      = '0;
      end
    endcase

    if (idex_flush) begin
      idex_en = 1'b1;
    end

    // Hold the pipeline frozen and bubbled for as long as reset is asserted.
    if (!rst) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      mul_busy   = 1'b0;
    end
  end

  assign state = state_q;

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!pc_en && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (ifid_flush && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed testbench for pipeline_hazard_ctrl (MUL_CYCLES=4, FLUSH_DEPTH=2).
// Statistics expectations follow HAZARD_STATS_EN, matching the build of the design.
module tb_pipeline_hazard_ctrl;

  localparam int REG_AW      = 4;
  localparam int MUL_CYCLES  = 4;
  localparam int FLUSH_DEPTH = 2;
  localparam int CNT_W       = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              id_valid, id_use_rs1, id_use_rs2, id_is_mul;
  logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
  logic              ex_valid, ex_memread, ex_branch_taken;
  logic              pc_en, ifid_en, ifid_flush, idex_en, idex_flush, mul_busy;
  logic [1:0]        state;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl #(
    .REG_AW     (REG_AW),
    .MUL_CYCLES (MUL_CYCLES),
    .FLUSH_DEPTH(FLUSH_DEPTH),
    .CNT_W      (CNT_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid       (id_valid),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .id_is_mul      (id_is_mul),
    .ex_valid       (ex_valid),
    .ex_rd          (ex_rd),
    .ex_memread     (ex_memread),
    .ex_branch_taken(ex_branch_taken),
    .pc_en          (pc_en),
    .ifid_en        (ifid_en),
    .ifid_flush     (ifid_flush),
    .idex_en        (idex_en),
    .idex_flush     (idex_flush),
    .mul_busy       (mul_busy),
    .state          (state),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic set_idle();
    id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    id_is_mul = 1'b0; ex_valid = 1'b0; ex_rd = '0; ex_memread = 1'b0; ex_branch_taken = 1'b0;
  endtask

  task automatic set_load_use(input logic [REG_AW-1:0] rd, input logic via_rs2);
    id_valid = 1'b1; ex_valid = 1'b1; ex_memread = 1'b1; ex_rd = rd;
    id_rs1 = via_rs2 ? 4'd9 : rd; id_use_rs1 = 1'b1;
    id_rs2 = via_rs2 ? rd : 4'd9; id_use_rs2 = via_rs2;
  endtask

  // Expected counts: the device may be built with or without statistics.
  function automatic logic [CNT_W-1:0] stat(input int n);
`ifdef HAZARD_STATS_EN
    return CNT_W'(n);
`else
    return CNT_W'(n * 0);
`endif
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      {id_valid, id_use_rs1, id_use_rs2, id_is_mul} = 4'($urandom);
      {ex_valid, ex_memread, ex_branch_taken} = 3'($urandom);
      id_rs1 = REG_AW'($urandom); id_rs2 = REG_AW'($urandom); ex_rd = REG_AW'($urandom);
      #1;
      checks++;
      if ({pc_en, ifid_en, idex_en, ifid_flush, idex_flush, mul_busy} !== 6'b000110) begin
        errors++; $display("[TB] FAIL reset_outputs: got %b expected 000110",
          {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, mul_busy});
      end
      checks++;
      if (state !== 2'd0 || stall_cnt !== '0 || flush_cnt !== '0) begin
        errors++; $display("[TB] FAIL reset_state: state=%0d stall=%0d flush=%0d expected 0/0/0",
          state, stall_cnt, flush_cnt);
      end
    end
    @(negedge clk);
    set_idle();
    rst = 1'b1;
    #1;
    checks++;
    if ({pc_en, ifid_en, idex_en, ifid_flush, idex_flush} !== 5'b11100) begin
      errors++; $display("[TB] FAIL run_idle: got %b expected 11100",
        {pc_en, ifid_en, idex_en, ifid_flush, idex_flush});
    end
  endtask

  task automatic test_load_use(input logic via_rs2);
    @(negedge clk);
    set_load_use(4'd5, via_rs2);
    #1;
    checks++;
    if ({pc_en, ifid_en, idex_en, idex_flush, ifid_flush} !== 5'b00110 || state !== 2'd0) begin
      errors++; $display("[TB] FAIL lu_stall(rs2=%0b): got %b state=%0d expected 00110 state=0",
        via_rs2, {pc_en, ifid_en, idex_en, idex_flush, ifid_flush}, state);
    end
    @(negedge clk);
    ex_valid = 1'b0;
    #1;
    checks++;
    if ({pc_en, ifid_en, idex_flush} !== 3'b110 || state !== 2'd0) begin
      errors++; $display("[TB] FAIL lu_release(rs2=%0b): got %b state=%0d expected 110 state=0",
        via_rs2, {pc_en, ifid_en, idex_flush}, state);
    end
  endtask

  task automatic test_lu_reg0();
    @(negedge clk);
    set_load_use(4'd0, 1'b0);
    #1;
    checks++;
    if ({pc_en, ifid_en, idex_flush} !== 3'b110) begin
      errors++; $display("[TB] FAIL lu_reg0: got %b expected 110", {pc_en, ifid_en, idex_flush});
    end
    @(negedge clk);
    set_load_use(4'd7, 1'b0);
    id_use_rs1 = 1'b0;
    #1;
    checks++;
    if ({pc_en, idex_flush} !== 2'b10) begin
      errors++; $display("[TB] FAIL lu_unused_src: got %b expected 10", {pc_en, idex_flush});
    end
  endtask

  task automatic test_multiply();
    @(negedge clk);
    set_idle();
    id_valid = 1'b1; id_is_mul = 1'b1;
    #1;
    checks++;
    if ({pc_en, ifid_en, idex_en, mul_busy} !== 4'b1110 || state !== 2'd0) begin
      errors++; $display("[TB] FAIL mul_issue: got %b state=%0d expected 1110 state=0",
        {pc_en, ifid_en, idex_en, mul_busy}, state);
    end
    for (int i = 0; i < MUL_CYCLES - 1; i++) begin
      @(negedge clk);
      set_load_use(4'd3, 1'b0);
      ex_branch_taken = 1'b1;
      #1;
      checks++;
      if ({pc_en, ifid_en, idex_en, ifid_flush, idex_flush, mul_busy} !== 6'b000001 ||
          state !== 2'd1) begin
        errors++; $display("[TB] FAIL mul_wait[%0d]: got %b state=%0d expected 000001 state=1",
          i, {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, mul_busy}, state);
      end
    end
    @(negedge clk);
    set_idle();
    #1;
    checks++;
    if ({pc_en, mul_busy} !== 2'b10 || state !== 2'd0) begin
      errors++; $display("[TB] FAIL mul_done: got %b state=%0d expected 10 state=0",
        {pc_en, mul_busy}, state);
    end
    checks++;
    if (stall_cnt !== stat(5)) begin
      errors++; $display("[TB] FAIL stall_cnt: got %0d expected %0d", stall_cnt, stat(5));
    end
  endtask

  task automatic test_branch_priority();
    @(negedge clk);
    set_load_use(4'd5, 1'b0);
    ex_branch_taken = 1'b1;
    #1;
    checks++;
    if ({pc_en, ifid_flush, idex_flush, idex_en} !== 4'b1111 || state !== 2'd0) begin
      errors++; $display("[TB] FAIL br_first: got %b state=%0d expected 1111 state=0",
        {pc_en, ifid_flush, idex_flush, idex_en}, state);
    end
    @(negedge clk);
    set_idle();
    #1;
    checks++;
    if ({pc_en, ifid_flush, idex_flush} !== 3'b111 || state !== 2'd2) begin
      errors++; $display("[TB] FAIL br_second: got %b state=%0d expected 111 state=2",
        {pc_en, ifid_flush, idex_flush}, state);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({pc_en, ifid_flush, idex_flush} !== 3'b100 || state !== 2'd0) begin
      errors++; $display("[TB] FAIL br_done: got %b state=%0d expected 100 state=0",
        {pc_en, ifid_flush, idex_flush}, state);
    end
    checks++;
    if (flush_cnt !== stat(2)) begin
      errors++; $display("[TB] FAIL flush_cnt: got %0d expected %0d", flush_cnt, stat(2));
    end
  endtask

  task automatic test_back_to_back_branch();
    @(negedge clk);
    ex_branch_taken = 1'b1;
    @(negedge clk);
    ex_branch_taken = 1'b1;
    #1;
    checks++;
    if (state !== 2'd2 || ifid_flush !== 1'b1) begin
      errors++; $display("[TB] FAIL b2b_reload: state=%0d flush=%b expected state=2 flush=1",
        state, ifid_flush);
    end
    @(negedge clk);
    ex_branch_taken = 1'b0;
    #1;
    checks++;
    if (state !== 2'd2 || {ifid_flush, idex_flush} !== 2'b11) begin
      errors++; $display("[TB] FAIL b2b_extended: state=%0d flush=%b expected state=2 flush=11",
        state, {ifid_flush, idex_flush});
    end
    @(negedge clk);
    #1;
    checks++;
    if (state !== 2'd0 || ifid_flush !== 1'b0 || flush_cnt !== stat(5)) begin
      errors++; $display("[TB] FAIL b2b_done: state=%0d flush=%b cnt=%0d expected 0/0/%0d",
        state, ifid_flush, flush_cnt, stat(5));
    end
  endtask

  task automatic test_reset_mid_mul();
    @(negedge clk);
    set_idle();
    id_valid = 1'b1; id_is_mul = 1'b1;
    @(negedge clk);
    set_idle();
    @(negedge clk);
    #1;
    checks++;
    if (state !== 2'd1 || mul_busy !== 1'b1) begin
      errors++; $display("[TB] FAIL rmm_setup: state=%0d busy=%b expected 1/1", state, mul_busy);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (state !== 2'd0 || mul_busy !== 1'b0 || pc_en !== 1'b0 || stall_cnt !== '0) begin
      errors++; $display("[TB] FAIL rmm_in_reset: state=%0d busy=%b pc_en=%b stall=%0d expected 0/0/0/0",
        state, mul_busy, pc_en, stall_cnt);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (state !== 2'd0 || mul_busy !== 1'b0 || pc_en !== 1'b1) begin
      errors++; $display("[TB] FAIL rmm_after: state=%0d busy=%b pc_en=%b expected 0/0/1",
        state, mul_busy, pc_en);
    end
  endtask

  initial begin
    set_idle();
    test_reset();
    test_load_use(1'b0);
    test_load_use(1'b1);
    test_lu_reg0();
    test_multiply();
    test_branch_priority();
    test_back_to_back_branch();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
